// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with valid/ready on both sides, occupancy
// counter, almost-flags, sticky error flags, flush and a high-watermark.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  rd_ready_i,
    input  logic                  flush_i,
    input  logic                  clear_errors_i,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic [ADDR_WIDTH:0]   max_level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);

    // Handshake: a transfer happens on a side only in a cycle where both its
    // valid and ready are high at the rising edge; flush cancels both sides.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [ADDR_WIDTH:0]   max_level_q, max_level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty, full, push, pop, ovf_set, udf_set;

    assign empty   = (level_q == '0);
    assign full    = (level_q == DEPTH_L);
    assign push    = wr_valid_i & ~full & ~flush_i;
    assign pop     = rd_ready_i & ~empty & ~flush_i;
    assign ovf_set = wr_valid_i & full & ~flush_i;
    assign udf_set = rd_ready_i & empty & ~flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = (clear_errors_i ? 1'b0 : overflow_q) | ovf_set;
        underflow_d = (clear_errors_i ? 1'b0 : underflow_q) | udf_set;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        // Watermark tracks the post-update level so a clear restarts from "now".
        if (clear_errors_i)            max_level_d = level_d;
        else if (level_d > max_level_q) max_level_d = level_d;
        else                           max_level_d = max_level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            max_level_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            max_level_q <= max_level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; only pointers define contents.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign wr_ready_o     = ~full;
    assign rd_valid_o     = ~empty;
    assign rd_data_o      = empty ? '0 : mem_q[rd_ptr_q];
    assign level_o        = level_q;
    assign max_level_o    = max_level_q;
    assign empty_o        = empty;
    assign full_o         = full;
    assign almost_empty_o = (level_q <= AE_L);
    assign almost_full_o  = (level_q >= AF_L);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;
endmodule
